score_display: RTL and testbench

Parametrised on-screen score counter and renderer for the VGA playfield. It holds a multi-digit BCD score that advances on a game event. It draws the score as seven-segment glyphs at a fixed screen position and produces registered 4-bit RGB plus a pixel-valid flag for the top-level colour mux. It replaces the fixed single-digit scoreboard with configurable digit count, position, glyph size, colour and overflow mode.

---
 rtl/score_display.sv | 172 +++++++++++++++++
 tb/tb_score_display.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// score_display: BCD score counter with seven-segment glyph renderer.
// Registered RGB and s_on for the playfield colour mux.
module score_display #(
  parameter int          DIGITS   = 2,
  parameter int          X0       = 720,
  parameter int          Y0       = 50,
  parameter int          T        = 5,
  parameter int          L        = 15,
  parameter int          GAP      = 5,
  parameter logic [11:0] FG       = 12'hFFF,
  parameter bit          WRAP     = 1'b1,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           Hcount,
  input  logic [15:0]           Vcount,
  input  logic                  score_inc,
  input  logic                  score_clr,
  output logic [3:0]            s_red,
  output logic [3:0]            s_green,
  output logic [3:0]            s_blue,
  output logic                  s_on,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  max_flag
);

  typedef logic [16:0] c17_t;

  localparam int   W     = 2*T + L;
  localparam int   H     = 3*T + 2*L;
  localparam int   PITCH = W + GAP;
  localparam int   NB    = 4*DIGITS;

  localparam c17_t CT   = c17_t'(T);
  localparam c17_t CTL  = c17_t'(T + L);
  localparam c17_t CW   = c17_t'(W);
  localparam c17_t C2TL = c17_t'(2*T + L);
  localparam c17_t C2T2 = c17_t'(2*T + 2*L);
  localparam c17_t CH   = c17_t'(H);
  localparam c17_t CY0  = c17_t'(Y0);

  // Lit segments {a,b,c,d,e,f,g} for a BCD digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Which segment region {a..g} a local glyph coordinate falls in.
  function automatic logic [6:0] seg_region(input c17_t x, input c17_t y);
    logic xl, xm, xr, y0, y1, y2, y3, y4;
    xl = (x < CT);
    xm = (x >= CT) && (x < CTL);
    xr = (x >= CTL) && (x < CW);
    y0 = (y < CT);
    y1 = (y >= CT) && (y < CTL);
    y2 = (y >= CTL) && (y < C2TL);
    y3 = (y >= C2TL) && (y < C2T2);
    y4 = (y >= C2T2) && (y < CH);
    return {xm & y0, xr & y1, xr & y3, xm & y4,
            xl & y3, xl & y1, xm & y2};
  endfunction

  logic          inc_q, inc_d;
  logic          pulse_q, pulse_d;
  logic [NB-1:0] score_q, score_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          on_q, on_d;

  logic [3:0]    dig [DIGITS];
  logic [DIGITS-1:0] blank;
  logic          all9;
  logic          carry;
  c17_t          lx [DIGITS];
  c17_t          ly;

  // Split score into digits; find all-9s and leading-zero blanking.
  always_comb begin
    logic lead;
    all9  = 1'b1;
    lead  = 1'b1;
    blank = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig[k] = score_q[4*(DIGITS-1-k) +: 4];
      all9   = all9 & (dig[k] == 4'd9);
      lead   = lead & (dig[k] == 4'd0);
      blank[k] = BLANK_LZ && lead && (k != DIGITS-1);
    end
  end

  // Edge detect and BCD increment; clear wins and cancels a pending event.
  always_comb begin
    inc_d   = score_inc;
    pulse_d = score_inc & ~inc_q & ~score_clr;
    score_d = score_q;
    carry   = 1'b0;
    if (score_clr) begin
      score_d = '0;
    end else if (pulse_q) begin
      if (all9 && !WRAP) begin
        score_d = score_q;
      end else begin
        carry = 1'b1;
        for (int k = DIGITS-1; k >= 0; k--) begin
          if (carry) begin
            if (dig[k] == 4'd9) begin
              score_d[4*(DIGITS-1-k) +: 4] = 4'd0;
            end else begin
              score_d[4*(DIGITS-1-k) +: 4] = dig[k] + 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
    end
  end

  // Per-pixel glyph hit test against every drawn digit box.
  always_comb begin
    logic hit;
    hit  = 1'b0;
    on_d = 1'b0;
    ly   = {1'b0, Vcount} - CY0;
    for (int k = 0; k < DIGITS; k++) begin
      lx[k] = {1'b0, Hcount} - c17_t'(X0 + k*PITCH);
      if (!blank[k] && (lx[k] < CW) && (ly < CH)) begin
        on_d = 1'b1;
        if (|(seg_region(lx[k], ly) & seg_decode(dig[k])))
          hit = 1'b1;
      end
    end
    rgb_d = hit ? FG : 12'h000;
  end

  // State and registered pixel outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_q   <= 1'b0;
      pulse_q <= 1'b0;
      score_q <= '0;
      rgb_q   <= 12'h000;
      on_q    <= 1'b0;
    end else begin
      inc_q   <= inc_d;
      pulse_q <= pulse_d;
      score_q <= score_d;
      rgb_q   <= rgb_d;
      on_q    <= on_d;
    end
  end

  assign s_red     = rgb_q[11:8];
  assign s_green   = rgb_q[7:4];
  assign s_blue    = rgb_q[3:0];
  assign s_on      = on_q;
  assign score_bcd = score_q;
  assign max_flag  = all9;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed checks of score_display.
// Three instances: defaults, saturating, 3-digit blanked.
module tb_score_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hc, vc;
  logic        inc, clr;

  logic [3:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic        on0, on1, on2, mx0, mx1, mx2;
  logic [7:0]  sc0, sc1;
  logic [11:0] sc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_display u_dut (
    .clk(clk), .reset(reset), .Hcount(hc), .Vcount(vc),
    .score_inc(inc), .score_clr(clr),
    .s_red(r0), .s_green(g0), .s_blue(b0), .s_on(on0),
    .score_bcd(sc0), .max_flag(mx0)
  );

  score_display #(.WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .Hcount(hc), .Vcount(vc),
    .score_inc(inc), .score_clr(clr),
    .s_red(r1), .s_green(g1), .s_blue(b1), .s_on(on1),
    .score_bcd(sc1), .max_flag(mx1)
  );

  score_display #(.DIGITS(3), .BLANK_LZ(1'b1)) u_lz (
    .clk(clk), .reset(reset), .Hcount(hc), .Vcount(vc),
    .score_inc(inc), .score_clr(clr),
    .s_red(r2), .s_green(g2), .s_blue(b2), .s_on(on2),
    .score_bcd(sc2), .max_flag(mx2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic pix(input int h, input int v);
    @(negedge clk);
    hc = 16'(h);
    vc = 16'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      inc = 1'b1;
      @(posedge clk); #1;
      inc = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic clear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    inc   = 1'b0;
    clr   = 1'b0;
    hc    = 16'd722;
    vc    = 16'd52;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {r0, g0, b0}, 32'h0);
    chk("rst_on", on0, 0);
    chk("rst_score", sc0, 32'h00);
    chk("rst_max", mx0, 0);

    @(negedge clk) reset = 1'b1;
    pix(722, 52);
    chk("corner_rgb", {r0, g0, b0}, 32'h000);
    chk("corner_on", on0, 1);
    pix(730, 52);
    chk("seg_a_rgb", {r0, g0, b0}, 32'hFFF);
    chk("seg_a_on", on0, 1);
    pix(730, 67);
    chk("mid_rgb", {r0, g0, b0}, 32'h000);
    chk("mid_on", on0, 1);
    pix(722, 60);
    chk("seg_f_rgb", {r0, g0, b0}, 32'hFFF);
    pix(700, 52);
    chk("left_on", on0, 0);
    chk("left_rgb", {r0, g0, b0}, 32'h000);
    pix(760, 52);
    chk("d1_a_rgb", {r0, g0, b0}, 32'hFFF);
    pix(745, 52);
    chk("gap_on", on0, 0);

    pulse(12);
    chk("cnt12", sc0, 32'h12);
    chk("cnt12_max", mx0, 0);
    inc = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    inc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("held_once", sc0, 32'h13);

    clear();
    chk("clr", sc0, 32'h00);
    pulse(99);
    chk("wrap_99", sc0, 32'h99);
    chk("wrap_99_max", mx0, 1);
    chk("sat_99", sc1, 32'h99);
    chk("sat_99_max", mx1, 1);
    chk("lz_099", sc2, 32'h099);
    chk("lz_099_max", mx2, 0);
    pulse(1);
    chk("wrap_00", sc0, 32'h00);
    chk("wrap_max_fall", mx0, 0);
    chk("sat_hold", sc1, 32'h99);
    chk("sat_max_hold", mx1, 1);
    chk("lz_100", sc2, 32'h100);

    clear();
    pulse(45);
    chk("cnt45", sc0, 32'h45);
    clr = 1'b1;
    inc = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    inc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("clr_wins", sc0, 32'h00);
    chk("clr_wins_lz", sc2, 32'h000);

    pulse(7);
    chk("lz_007", sc2, 32'h007);
    pix(730, 52);
    chk("lz_box0_on", on2, 0);
    chk("dflt_box0_rgb", {r0, g0, b0}, 32'hFFF);
    pix(760, 52);
    chk("lz_box1_on", on2, 0);
    pix(802, 80);
    chk("lz_seg_c_rgb", {r2, g2, b2}, 32'hFFF);
    chk("lz_seg_c_on", on2, 1);
    pix(782, 60);
    chk("lz_f_unlit", {r2, g2, b2}, 32'h000);
    chk("lz_f_on", on2, 1);

    pix(730, 52);
    chk("pre_rst_rgb", {r0, g0, b0}, 32'hFFF);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("midrst_rgb", {r0, g0, b0}, 32'h000);
    chk("midrst_on", on0, 0);
    chk("midrst_score", sc0, 32'h00);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("resume_rgb", {r0, g0, b0}, 32'hFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
